// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, one word read per cycle, DEPTH-entry instruction/PC FIFO to decode.
// Optional macro FETCH_STALL_CNT_EN adds a saturating decode-starved cycle counter on stall_cnt.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [INST_W-1:0] dec_instr,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [31:0]       stall_cnt
);
   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W+1:0]  DEPTH_L = (PTR_W+2)'(DEPTH);

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] req_pc_reg;
   logic              inflight_reg;
   logic              kill_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W:0]    count_reg;

   logic [INST_W-1:0] instr_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem    [DEPTH];

   logic              push;
   logic              pop;
   logic [PTR_W+1:0]  credit_used;

   // A request is only issued when the FIFO has room for its response, so pushes never overflow.
   assign credit_used = {1'b0, count_reg} + {{(PTR_W+1){1'b0}}, inflight_reg};
   assign imem_req    = reset && !redirect_valid && (credit_used < DEPTH_L);
   assign imem_addr   = pc_reg;

   assign dec_valid = (count_reg != '0);
   assign dec_instr = dec_valid ? instr_mem[rd_ptr_reg] : '0;
   assign dec_pc    = dec_valid ? pc_mem[rd_ptr_reg]    : '0;

   assign push = inflight_reg && !kill_reg && !redirect_valid;
   assign pop  = dec_valid && dec_ready && !redirect_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg       <= RESET_PC;
         req_pc_reg   <= '0;
         inflight_reg <= 1'b0;
         kill_reg     <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         kill_reg     <= redirect_valid;
         inflight_reg <= imem_req;
         if (redirect_valid) begin
            pc_reg <= redirect_pc & ~ADDR_W'(3);
         end else if (imem_req) begin
            pc_reg     <= pc_reg + ADDR_W'(4);
            req_pc_reg <= pc_reg;
         end
         // Redirect flushes the queue and discards any same-cycle pop or arriving response.
         if (redirect_valid) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
               2'b10:   count_reg <= count_reg + 1'b1;
               2'b01:   count_reg <= count_reg - 1'b1;
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_reg] <= imem_rdata;
         pc_mem[wr_ptr_reg]    <= req_pc_reg;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Counts cycles where decode is ready but starved; survives redirects, saturates at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt_reg <= '0;
      else if (dec_ready && !dec_valid && (stall_cnt_reg != 32'hFFFF_FFFF))
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign stall_cnt = stall_cnt_reg;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
